dmem_sram_if: RTL
=================

# dmem_sram_if

Data-memory access unit sitting directly downstream of the pipeline's memory stage. It turns a single-cycle memory request (address, byte write enables, write data, size) into a transaction on a stalling SRAM-like bus (req / addr_ok / data_ok). It stalls the pipeline until the data returns and holds the load result stable while other hazards keep the pipeline frozen.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; byte lanes = DATA_W/8.

Ports:
- `clk`, in, 1: clock; all state on rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `memreq_i`, in, 1: M-stage instruction is a load or store.
- `memwen_i`, in, 4: byte write enables; 0 means load.
- `size_i`, in, 2: 0 byte, 1 half, 2 word.
- `addr_i`, in, ADDR_W: virtual byte address.
- `wdata_i`, in, DATA_W: store data, already lane-replicated.
- `cancel_i`, in, 1: M-stage request flushed (exception or eret).
- `pipe_stall_i`, in, 1: pipeline frozen by another source.
- `rdata_o`, out, DATA_W: load data to the writeback register.
- `stall_o`, out, 1: memory access not complete; freezes the pipeline.
- `data_req`, out, 1: bus request.
- `data_wr`, out, 1: write transaction.
- `data_size`, out, 2: equals size_i.
- `data_addr`, out, ADDR_W: physical address.
- `data_wstrb`, out, 4: equals memwen_i.
- `data_wdata`, out, DATA_W: equals wdata_i.
- `data_addr_ok`, in, 1: request accepted.
- `data_data_ok`, in, 1: response (read data or write acknowledge).
- `data_rdata`, in, DATA_W: read data, valid with data_ok.

## Operation
- FSM states:
  - IDLE:
    - memreq_i & ~cancel_i: go to REQ.
  - REQ:
    - data_req=1.
    - cancel_i before acceptance: go to IDLE, no bus transfer.
    - data_addr_ok: go to WAIT.
  - WAIT:
    - data_data_ok: go to DONE, and capture data_rdata into the rdata register (loads only).
    - data_data_ok with the drop flag set: go to IDLE instead, and capture nothing.
  - DONE:
    - ~pipe_stall_i: go to IDLE.
- stall_o = memreq_i & ~cancel_i & (state ≠ DONE), plus 1 whenever the state is WAIT with the drop flag set.
- cancel_i in WAIT:
  - Sets the drop flag; the transaction cannot be withdrawn.
  - The outstanding response is drained and discarded.
  - The drop flag is cleared when the state returns to IDLE.
- Bus fields (data_wr, data_size, data_addr, data_wstrb, data_wdata) are held constant from REQ entry until addr_ok.
  - They are driven from registers latched on IDLE→REQ.
- Only one outstanding transaction at a time.
- A data_ok arriving in any state other than WAIT is ignored.
- rdata_o is the registered value. It holds in DONE, and keeps its last value until the next capture.

## Timing
- Reset values:
  - state=IDLE, data_req=0, data_wr=0, data_size=0, data_addr=0, data_wstrb=0, data_wdata=0.
  - rdata_o=0, drop flag=0.
  - stall_o follows its combinational equation.
- Minimum latency, with addr_ok and data_ok each asserted in the first cycle possible:
  - cycle 0: memreq_i seen, stall_o=1, IDLE→REQ.
  - cycle 1: data_req=1 with addr_ok, →WAIT.
  - cycle 2: data_ok, →DONE.
  - cycle 3: stall_o=0.
  - Four cycles total, from memreq_i to stall_o low.
- Back-to-back requests: DONE→IDLE, then a new request is seen the following cycle. At most one idle bubble between transactions.
- Reset mid-transaction:
  - Returns to IDLE immediately.
  - The bus side is expected to reset on the same signal.

## Configuration
- `DMEM_ADDR_MAP_EN` defined:
  - Fixed MIPS mapping: kseg0/kseg1 (addr[31:30]==2'b10) → data_addr = {3'b000, addr_i[28:0]}.
  - Other segments pass through unchanged.
- Undefined: data_addr = addr_i.

## Structure
- Shared package `dmem_pkg` holds:
  - state enum: IDLE, REQ, WAIT, DONE;
  - size constants: SIZE_B=0, SIZE_H=1, SIZE_W=2;
  - the kseg mask constant.
- One sub-module, `dmem_addr_map`, is natural.
  - Combinational address translation.
  - Wraps the macro-controlled logic.

## Test plan
- Load word, addr_i=0x80001000 with macro on, addr_ok and data_ok each one cycle after their trigger, data_rdata=0xDEADBEEF:
  - data_addr=0x00001000, data_wr=0;
  - stall_o high 3 cycles;
  - rdata_o=0xDEADBEEF.
- Store byte, memwen_i=4'b0100, size_i=0, addr=0xBFAF0002, wdata=0x00550000, addr_ok delayed 3 cycles:
  - bus fields stable across all REQ cycles;
  - data_wr=1, data_wstrb=4'b0100.
- Load completes while pipe_stall_i=1 for 5 cycles:
  - state stays DONE, stall_o=0;
  - rdata_o constant at the captured value;
  - IDLE on the first cycle with pipe_stall_i=0.
- cancel_i in REQ before addr_ok: data_req drops the next cycle, no data_ok expected, state=IDLE.
- cancel_i in WAIT, data_ok 2 cycles later with rdata=0x12345678:
  - stall_o held until data_ok;
  - rdata_o unchanged;
  - next request issues normally.
- rst asserted in WAIT: immediate return to IDLE, all outputs at reset values.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory SRAM interface.
// The DMEM_ADDR_MAP_EN build option is handled in dmem_addr_map.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } dmemState_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // kseg0/kseg1 are identified by the top two address bits; the mask strips the segment bits
    localparam logic [1:0]  KSEG01_TOP = 2'b10;
    localparam logic [31:0] KSEG_MASK  = 32'h1FFF_FFFF;

endpackage

// File: rtl/dmem_addr_map.sv
// Combinational virtual-to-physical address translation for data accesses.
// With DMEM_ADDR_MAP_EN defined, kseg0/kseg1 fold onto physical zero; otherwise the address passes through.
module dmem_addr_map
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] virtAddr,
    output logic [ADDR_W-1:0] physAddr
);

`ifdef DMEM_ADDR_MAP_EN
    always_comb begin
        physAddr = virtAddr;
        if (virtAddr[ADDR_W-1 -: 2] == KSEG01_TOP) begin
            physAddr = virtAddr & ADDR_W'(KSEG_MASK);
        end
    end
`else
    assign physAddr = virtAddr;
`endif

endmodule

// File: rtl/dmem_sram_if.sv
// Memory-stage to SRAM-like bus bridge: one outstanding transaction, pipeline stall until completion.
// Address translation is selected by the DMEM_ADDR_MAP_EN build option (see dmem_addr_map).
module dmem_sram_if
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memreq_i,
    input  logic [3:0]        memwen_i,
    input  logic [1:0]        size_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              cancel_i,
    input  logic              pipe_stall_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              stall_o,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    dmemState_e        state;
    dmemState_e        nextState;
    logic              dropFlag;
    logic              startReq;
    logic              dropResp;
    logic [ADDR_W-1:0] physAddr;
    logic [DATA_W-1:0] rdataReg;
    logic              busWr;
    logic [1:0]        busSize;
    logic [ADDR_W-1:0] busAddr;
    logic [3:0]        busWstrb;
    logic [DATA_W-1:0] busWdata;

    dmem_addr_map #(.ADDR_W(ADDR_W)) uAddrMap (
        .virtAddr (addr_i),
        .physAddr (physAddr)
    );

    assign startReq = (state == IDLE) && memreq_i && !cancel_i;
    // A flush arriving together with the response must not write back either
    assign dropResp = dropFlag || cancel_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Acceptance wins over a simultaneous cancel: once addr_ok is seen a response will follow
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (startReq) nextState = REQ;
            REQ: begin
                if (data_addr_ok) begin
                    nextState = WAIT;
                end else if (cancel_i) begin
                    nextState = IDLE;
                end
            end
            WAIT: if (data_data_ok) nextState = dropResp ? IDLE : DONE;
            DONE: if (!pipe_stall_i) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        data_req = (state == REQ);
        stall_o  = (memreq_i && !cancel_i && (state != DONE)) || ((state == WAIT) && dropFlag);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dropFlag <= 1'b0;
        end else if (nextState == IDLE) begin
            dropFlag <= 1'b0;
        end else if (cancel_i && ((state == WAIT) || ((state == REQ) && data_addr_ok))) begin
            dropFlag <= 1'b1;
        end
    end

    // Bus fields are frozen at request start so the bus sees a stable transaction until accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busWr    <= 1'b0;
            busSize  <= 2'd0;
            busAddr  <= '0;
            busWstrb <= 4'd0;
            busWdata <= '0;
        end else if (startReq) begin
            busWr    <= (memwen_i != 4'd0);
            busSize  <= size_i;
            busAddr  <= physAddr;
            busWstrb <= memwen_i;
            busWdata <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdataReg <= '0;
        end else if ((state == WAIT) && data_data_ok && !dropResp && !busWr) begin
            rdataReg <= data_rdata;
        end
    end

    assign rdata_o    = rdataReg;
    assign data_wr    = busWr;
    assign data_size  = busSize;
    assign data_addr  = busAddr;
    assign data_wstrb = busWstrb;
    assign data_wdata = busWdata;

endmodule
